// File: rtl/transport_pkg.sv
// Shared constants and FSM encoding for the receive-side transport parser.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package transport_pkg;

    // Packet framing bytes
    localparam logic [7:0] HDR_CTRL  = 8'h40;
    localparam logic [7:0] HDR_AUDIO = 8'h80;
    localparam logic [7:0] TRAILER   = 8'hFF;

    // Error codes reported on err_code
    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_HEADER   = 2'b01;
    localparam logic [1:0] ERR_TRAILER  = 2'b10;
    localparam logic [1:0] ERR_OVERFLOW = 2'b11;

    // Parser states; encodings are fixed so they stay stable across revisions
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CTRL_HI = 3'd1,
        ST_CTRL_LO = 3'd2,
        ST_PAD     = 3'd3,
        ST_AUD_HI  = 3'd4,
        ST_AUD_LO  = 3'd5,
        ST_TRAILER = 3'd6,
        ST_DISCARD = 3'd7
    } rx_state_t;

endpackage

// File: rtl/sample_fifo.sv
// Show-ahead synchronous FIFO holding decoded audio samples.
// Latency: a write is visible on rd_data/empty/count the cycle after the write edge.
// Backpressure: none; a write to a full FIFO is dropped unless a read happens on the same edge.
module sample_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);
    // A pop on a full FIFO frees the slot the same-edge write lands in.
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);
    // Drive zero when empty so the output is clean after reset and after drain.
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // Sample storage; contents need no reset because empty masks rd_data.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally; count carries one extra bit to represent full.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/transport_receive.sv
// Parses fixed-length transport packets into control words and buffered audio samples.
// Latency: ctrl/err/pkt_busy one cycle after the deciding byte; samples visible one cycle after their low byte.
// Backpressure: none; accepts one byte per cycle, overflowing samples are dropped and flagged.
module transport_receive
    import transport_pkg::*;
#(
    parameter int PACKET_SIZE = 16,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic [7:0]                    in_data,
    output logic                          pkt_busy,
    output logic                          ctrl_valid,
    output logic [15:0]                   ctrl_data,
    output logic                          audio_valid,
    output logic [15:0]                   audio_data,
    input  logic                          audio_rd,
    output logic [$clog2(FIFO_DEPTH):0]   audio_count,
    output logic                          err,
    output logic [1:0]                    err_code
);

    localparam int CNT_W = $clog2(PACKET_SIZE);
    localparam logic [CNT_W-1:0] LAST_CNT        = CNT_W'(PACKET_SIZE - 1);
    localparam logic [CNT_W-1:0] LAST_SAMPLE_CNT = CNT_W'(PACKET_SIZE - 2);

    rx_state_t        state;
    rx_state_t        state_nxt;
    logic [CNT_W-1:0] byte_cnt;
    logic [7:0]       hi_byte;
    logic             last_byte;
    logic             fifo_wr;
    logic             fifo_full;
    logic             fifo_empty;
    logic             overflow;
    logic             bad_hdr;
    logic             bad_trl;

    assign last_byte = in_valid && (byte_cnt == LAST_CNT);
    assign fifo_wr   = in_valid && (state == ST_AUD_LO);
    // Full implies non-empty, so a raised audio_rd always frees a slot here.
    assign overflow  = fifo_wr && fifo_full && !audio_rd;
    assign bad_hdr   = in_valid && (state == ST_IDLE)
                       && (in_data != HDR_CTRL) && (in_data != HDR_AUDIO);
    assign bad_trl   = in_valid && (state == ST_TRAILER) && (in_data != TRAILER);

    assign pkt_busy    = (state != ST_IDLE);
    assign audio_valid = !fifo_empty;

    // Next-state decode; the parser only advances on accepted bytes.
    always_comb begin
        state_nxt = state;
        if (in_valid) begin
            case (state)
                ST_IDLE: begin
                    if (in_data == HDR_CTRL) begin
                        state_nxt = ST_CTRL_HI;
                    end else if (in_data == HDR_AUDIO) begin
                        state_nxt = ST_AUD_HI;
                    end else begin
                        state_nxt = ST_DISCARD;
                    end
                end
                ST_CTRL_HI: state_nxt = ST_CTRL_LO;
                ST_CTRL_LO: state_nxt = ST_PAD;
                ST_PAD,
                ST_DISCARD: begin
                    if (byte_cnt == LAST_CNT) begin
                        state_nxt = ST_IDLE;
                    end
                end
                ST_AUD_HI: state_nxt = ST_AUD_LO;
                ST_AUD_LO: begin
                    if (byte_cnt == LAST_SAMPLE_CNT) begin
                        state_nxt = ST_TRAILER;
                    end else begin
                        state_nxt = ST_AUD_HI;
                    end
                end
                ST_TRAILER: state_nxt = ST_IDLE;
                default:    state_nxt = ST_IDLE;
            endcase
        end
    end

    // Parser state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Position within the packet; wraps to zero after the final byte.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_cnt <= '0;
        end else if (in_valid) begin
            if (last_byte) begin
                byte_cnt <= '0;
            end else begin
                byte_cnt <= byte_cnt + 1'b1;
            end
        end
    end

    // Hold the MSB of a control word or sample until its LSB arrives.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_byte <= '0;
        end else if (in_valid && ((state == ST_CTRL_HI) || (state == ST_AUD_HI))) begin
            hi_byte <= in_data;
        end
    end

    // Control word capture with a single-cycle valid pulse; the word is held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_valid <= 1'b0;
            ctrl_data  <= '0;
        end else begin
            ctrl_valid <= in_valid && (state == ST_CTRL_LO);
            if (in_valid && (state == ST_CTRL_LO)) begin
                ctrl_data <= {hi_byte, in_data};
            end
        end
    end

    // Error pulse and sticky code; overflow outranks a bad trailer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err      <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            err <= overflow || bad_trl || bad_hdr;
            if (overflow) begin
                err_code <= ERR_OVERFLOW;
            end else if (bad_trl) begin
                err_code <= ERR_TRAILER;
            end else if (bad_hdr) begin
                err_code <= ERR_HEADER;
            end
        end
    end

    sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (16)
    ) u_sample_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (fifo_wr),
        .wr_data ({hi_byte, in_data}),
        .rd_en   (audio_rd),
        .rd_data (audio_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (audio_count)
    );

endmodule

// File: tb/tb_transport_receive.sv
// Testbench for transport_receive: randomized packets against a packet-level reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_transport_receive;

    localparam int PS = 16;
    localparam int FD = 16;
    localparam int NSAMP = (PS - 2) / 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        audio_rd = 1'b0;
    logic        pkt_busy;
    logic        ctrl_valid;
    logic [15:0] ctrl_data;
    logic        audio_valid;
    logic [15:0] audio_data;
    logic [$clog2(FD):0] audio_count;
    logic        err;
    logic [1:0]  err_code;

    transport_receive #(.PACKET_SIZE(PS), .FIFO_DEPTH(FD)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .pkt_busy    (pkt_busy),
        .ctrl_valid  (ctrl_valid),
        .ctrl_data   (ctrl_data),
        .audio_valid (audio_valid),
        .audio_data  (audio_data),
        .audio_rd    (audio_rd),
        .audio_count (audio_count),
        .err         (err),
        .err_code    (err_code)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [15:0] got_ctrl [$];
    logic [15:0] exp_ctrl [$];
    logic [15:0] got_aud  [$];
    logic [15:0] exp_aud  [$];
    logic [1:0]  got_err  [$];
    logic [1:0]  exp_err  [$];
    logic [7:0]  pkt [PS];
    int          model_occ = 0;
    bit          gaps = 1'b0;

    // Passive monitor, sampling half a cycle away from the active edge.
    always @(negedge clk) begin
        if (reset) begin
            if (ctrl_valid) got_ctrl.push_back(ctrl_data);
            if (err) got_err.push_back(err_code);
            if (audio_rd && audio_valid) got_aud.push_back(audio_data);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        if (gaps) repeat ($urandom_range(0, 3)) tick();
        in_valid = 1'b1;
        in_data  = b;
        tick();
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic send_pkt();
        for (int i = 0; i < PS; i++) send_byte(pkt[i]);
    endtask

    task automatic settle();
        repeat (3) tick();
    endtask

    task automatic clear_all();
        got_ctrl.delete(); exp_ctrl.delete();
        got_aud.delete();  exp_aud.delete();
        got_err.delete();  exp_err.delete();
        model_occ = 0;
    endtask

    task automatic build_ctrl(input logic [15:0] w, input bit zero_pad);
        pkt[0] = 8'h40;
        pkt[1] = w[15:8];
        pkt[2] = w[7:0];
        for (int i = 3; i < PS; i++) pkt[i] = zero_pad ? 8'h00 : 8'($urandom);
    endtask

    task automatic build_audio(input logic [7:0] trl, input bit counting);
        logic [15:0] s;
        pkt[0] = 8'h80;
        for (int i = 0; i < NSAMP; i++) begin
            s = counting ? 16'(i + 1) : 16'($urandom);
            pkt[1 + 2 * i] = s[15:8];
            pkt[2 + 2 * i] = s[7:0];
        end
        pkt[PS - 1] = trl;
    endtask

    task automatic build_bad();
        logic [7:0] h;
        do h = 8'($urandom); while (h == 8'h40 || h == 8'h80);
        pkt[0] = h;
        for (int i = 1; i < PS; i++) pkt[i] = 8'($urandom);
    endtask

    // Packet-level reference: what the current pkt[] must produce.
    task automatic model_pkt(input bit rd_active);
        if (pkt[0] == 8'h40) begin
            exp_ctrl.push_back({pkt[1], pkt[2]});
        end else if (pkt[0] == 8'h80) begin
            for (int i = 0; i < NSAMP; i++) begin
                if (rd_active || model_occ < FD) begin
                    exp_aud.push_back({pkt[1 + 2 * i], pkt[2 + 2 * i]});
                    if (!rd_active) model_occ++;
                end else begin
                    exp_err.push_back(2'b11);
                end
            end
            if (pkt[PS - 1] != 8'hFF) exp_err.push_back(2'b10);
        end else begin
            exp_err.push_back(2'b01);
        end
    endtask

    task automatic drain();
        audio_rd = 1'b1;
        for (int n = 0; n < 64 && audio_valid; n++) tick();
        checks++;
        if (audio_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_timeout audio_valid=%b exp=0", audio_valid);
        end
        audio_rd = 1'b0;
        model_occ = 0;
        tick();
    endtask

    task automatic test_reset();
        logic [15:0] obs [8];
        string nm [8];
        reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        @(negedge clk);
        obs = '{16'(pkt_busy), 16'(ctrl_valid), ctrl_data, 16'(audio_valid),
                audio_data, 16'(audio_count), 16'(err), 16'(err_code)};
        nm = '{"pkt_busy", "ctrl_valid", "ctrl_data", "audio_valid",
               "audio_data", "audio_count", "err", "err_code"};
        foreach (obs[i]) begin
            checks++;
            if (obs[i] !== 16'h0) begin
                errors++;
                $display("FAIL reset_%s got=%h exp=0", nm[i], obs[i]);
            end
        end
        tick();
    endtask

    task automatic test_control();
        clear_all();
        build_ctrl(16'h1234, 1'b1);
        model_pkt(1'b0);
        send_byte(pkt[0]);
        @(negedge clk);
        checks++;
        if (pkt_busy !== 1'b1) begin errors++; $display("FAIL ctrl_busy_hi got=%b exp=1", pkt_busy); end
        for (int i = 1; i < PS; i++) send_byte(pkt[i]);
        @(negedge clk);
        checks++;
        if (pkt_busy !== 1'b0) begin errors++; $display("FAIL ctrl_busy_lo got=%b exp=0", pkt_busy); end
        settle();
        checks++;
        if (got_ctrl.size() != 1 || got_ctrl[0] !== 16'h1234) begin
            errors++; $display("FAIL ctrl_word n=%0d got=%h exp=1234", got_ctrl.size(), got_ctrl.size() ? got_ctrl[0] : 16'hx);
        end
        checks++;
        if (got_err.size() != 0) begin errors++; $display("FAIL ctrl_noerr got=%0d exp=0", got_err.size()); end
        checks++;
        if (ctrl_data !== 16'h1234) begin errors++; $display("FAIL ctrl_held got=%h exp=1234", ctrl_data); end
    endtask

    task automatic test_audio();
        clear_all();
        build_audio(8'hFF, 1'b1);
        model_pkt(1'b0);
        send_pkt();
        settle();
        checks++;
        if (audio_count !== 5'(NSAMP)) begin errors++; $display("FAIL aud_count got=%0d exp=%0d", audio_count, NSAMP); end
        checks++;
        if (audio_data !== 16'h0001) begin errors++; $display("FAIL aud_head got=%h exp=0001", audio_data); end
        drain();
        checks++;
        if (got_aud.size() != exp_aud.size()) begin
            errors++; $display("FAIL aud_num got=%0d exp=%0d", got_aud.size(), exp_aud.size());
        end else foreach (exp_aud[i]) begin
            checks++;
            if (got_aud[i] !== exp_aud[i]) begin errors++; $display("FAIL aud_word[%0d] got=%h exp=%h", i, got_aud[i], exp_aud[i]); end
        end
        checks++;
        if (got_err.size() != 0) begin errors++; $display("FAIL aud_noerr got=%0d exp=0", got_err.size()); end
        checks++;
        if (audio_count !== '0) begin errors++; $display("FAIL aud_empty got=%0d exp=0", audio_count); end
    endtask

    task automatic test_bad_header();
        clear_all();
        build_bad();
        model_pkt(1'b0);
        send_pkt();
        build_ctrl(16'($urandom), 1'b0);
        model_pkt(1'b0);
        send_pkt();
        settle();
        checks++;
        if (got_err.size() != 1 || got_err[0] !== 2'b01) begin
            errors++; $display("FAIL badhdr_err n=%0d got=%b exp=01", got_err.size(), got_err.size() ? got_err[0] : 2'bx);
        end
        checks++;
        if (got_ctrl.size() != 1 || got_ctrl[0] !== exp_ctrl[0]) begin
            errors++; $display("FAIL badhdr_ctrl n=%0d got=%h exp=%h", got_ctrl.size(), got_ctrl.size() ? got_ctrl[0] : 16'hx, exp_ctrl[0]);
        end
        checks++;
        if (err_code !== 2'b01) begin errors++; $display("FAIL badhdr_code_held got=%b exp=01", err_code); end
    endtask

    task automatic test_bad_trailer();
        clear_all();
        build_audio(8'hEE, 1'b0);
        model_pkt(1'b0);
        send_pkt();
        settle();
        checks++;
        if (audio_count !== 5'(NSAMP)) begin errors++; $display("FAIL badtrl_count got=%0d exp=%0d", audio_count, NSAMP); end
        checks++;
        if (got_err.size() != 1 || got_err[0] !== 2'b10) begin
            errors++; $display("FAIL badtrl_err n=%0d got=%b exp=10", got_err.size(), got_err.size() ? got_err[0] : 2'bx);
        end
        drain();
        checks++;
        if (got_aud.size() != exp_aud.size()) begin
            errors++; $display("FAIL badtrl_num got=%0d exp=%0d", got_aud.size(), exp_aud.size());
        end else foreach (exp_aud[i]) begin
            checks++;
            if (got_aud[i] !== exp_aud[i]) begin errors++; $display("FAIL badtrl_word[%0d] got=%h exp=%h", i, got_aud[i], exp_aud[i]); end
        end
    endtask

    task automatic test_overflow();
        clear_all();
        repeat (3) begin
            build_audio(8'hFF, 1'b0);
            model_pkt(1'b0);
            send_pkt();
        end
        settle();
        checks++;
        if (audio_count !== 5'(FD)) begin errors++; $display("FAIL ovf_count got=%0d exp=%0d", audio_count, FD); end
        checks++;
        if (err_code !== 2'b11) begin errors++; $display("FAIL ovf_code got=%b exp=11", err_code); end
        checks++;
        if (got_err.size() != exp_err.size()) begin
            errors++; $display("FAIL ovf_nerr got=%0d exp=%0d", got_err.size(), exp_err.size());
        end else foreach (exp_err[i]) begin
            checks++;
            if (got_err[i] !== exp_err[i]) begin errors++; $display("FAIL ovf_err[%0d] got=%b exp=%b", i, got_err[i], exp_err[i]); end
        end
        drain();
        checks++;
        if (got_aud.size() != exp_aud.size()) begin
            errors++; $display("FAIL ovf_num got=%0d exp=%0d", got_aud.size(), exp_aud.size());
        end else foreach (exp_aud[i]) begin
            checks++;
            if (got_aud[i] !== exp_aud[i]) begin errors++; $display("FAIL ovf_word[%0d] got=%h exp=%h", i, got_aud[i], exp_aud[i]); end
        end
        // Same traffic with the consumer always ready: nothing may drop.
        clear_all();
        audio_rd = 1'b1;
        repeat (3) begin
            build_audio(8'hFF, 1'b0);
            model_pkt(1'b1);
            send_pkt();
        end
        settle();
        drain();
        checks++;
        if (got_err.size() != 0) begin errors++; $display("FAIL rdhi_noerr got=%0d exp=0", got_err.size()); end
        checks++;
        if (got_aud.size() != exp_aud.size()) begin
            errors++; $display("FAIL rdhi_num got=%0d exp=%0d", got_aud.size(), exp_aud.size());
        end else foreach (exp_aud[i]) begin
            checks++;
            if (got_aud[i] !== exp_aud[i]) begin errors++; $display("FAIL rdhi_word[%0d] got=%h exp=%h", i, got_aud[i], exp_aud[i]); end
        end
    endtask

    task automatic test_random_gaps();
        int kind;
        clear_all();
        gaps = 1'b1;
        for (int p = 0; p < 16; p++) begin
            kind = $urandom_range(0, 3);
            case (kind)
                0: build_ctrl(16'($urandom), 1'b0);
                1: build_audio(8'hFF, 1'b0);
                2: build_audio(8'($urandom_range(0, 254)), 1'b0);
                default: build_bad();
            endcase
            model_pkt(1'b0);
            send_pkt();
            settle();
            drain();
        end
        gaps = 1'b0;
        checks++;
        if (got_ctrl.size() != exp_ctrl.size()) begin
            errors++; $display("FAIL gap_nctrl got=%0d exp=%0d", got_ctrl.size(), exp_ctrl.size());
        end else foreach (exp_ctrl[i]) begin
            checks++;
            if (got_ctrl[i] !== exp_ctrl[i]) begin errors++; $display("FAIL gap_ctrl[%0d] got=%h exp=%h", i, got_ctrl[i], exp_ctrl[i]); end
        end
        checks++;
        if (got_err.size() != exp_err.size()) begin
            errors++; $display("FAIL gap_nerr got=%0d exp=%0d", got_err.size(), exp_err.size());
        end else foreach (exp_err[i]) begin
            checks++;
            if (got_err[i] !== exp_err[i]) begin errors++; $display("FAIL gap_err[%0d] got=%b exp=%b", i, got_err[i], exp_err[i]); end
        end
        checks++;
        if (got_aud.size() != exp_aud.size()) begin
            errors++; $display("FAIL gap_naud got=%0d exp=%0d", got_aud.size(), exp_aud.size());
        end else foreach (exp_aud[i]) begin
            checks++;
            if (got_aud[i] !== exp_aud[i]) begin errors++; $display("FAIL gap_aud[%0d] got=%h exp=%h", i, got_aud[i], exp_aud[i]); end
        end
    endtask

    task automatic test_reset_mid_packet();
        logic [15:0] obs [8];
        string nm [8];
        clear_all();
        build_ctrl(16'hBEEF, 1'b0);
        send_pkt();
        build_bad();
        send_pkt();
        build_audio(8'hFF, 1'b0);
        send_pkt();
        build_audio(8'hFF, 1'b0);
        for (int i = 0; i < 6; i++) send_byte(pkt[i]);
        #2 reset = 1'b0;
        @(negedge clk);
        obs = '{16'(pkt_busy), 16'(ctrl_valid), ctrl_data, 16'(audio_valid),
                audio_data, 16'(audio_count), 16'(err), 16'(err_code)};
        nm = '{"pkt_busy", "ctrl_valid", "ctrl_data", "audio_valid",
               "audio_data", "audio_count", "err", "err_code"};
        foreach (obs[i]) begin
            checks++;
            if (obs[i] !== 16'h0) begin
                errors++;
                $display("FAIL midrst_%s got=%h exp=0", nm[i], obs[i]);
            end
        end
        tick();
        reset = 1'b1;
        tick();
        clear_all();
        build_ctrl(16'($urandom), 1'b0);
        model_pkt(1'b0);
        send_pkt();
        build_audio(8'hFF, 1'b0);
        model_pkt(1'b0);
        send_pkt();
        settle();
        checks++;
        if (audio_count !== 5'(NSAMP)) begin errors++; $display("FAIL midrst_count got=%0d exp=%0d", audio_count, NSAMP); end
        drain();
        checks++;
        if (got_ctrl.size() != 1 || got_ctrl[0] !== exp_ctrl[0]) begin
            errors++; $display("FAIL midrst_ctrl n=%0d got=%h exp=%h", got_ctrl.size(), got_ctrl.size() ? got_ctrl[0] : 16'hx, exp_ctrl[0]);
        end
        checks++;
        if (got_err.size() != 0) begin errors++; $display("FAIL midrst_noerr got=%0d exp=0", got_err.size()); end
        checks++;
        if (got_aud.size() != exp_aud.size()) begin
            errors++; $display("FAIL midrst_naud got=%0d exp=%0d", got_aud.size(), exp_aud.size());
        end else foreach (exp_aud[i]) begin
            checks++;
            if (got_aud[i] !== exp_aud[i]) begin errors++; $display("FAIL midrst_aud[%0d] got=%h exp=%h", i, got_aud[i], exp_aud[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_control();
        test_audio();
        test_bad_header();
        test_bad_trailer();
        test_overflow();
        test_random_gaps();
        test_reset_mid_packet();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/transport_receive.md
# transport_receive

Receive-side transport stage, directly downstream of the packet sender's ready-packet output. It consumes the fixed-length byte stream produced by `transportSend`, parses each packet by header byte, and separates it into two outputs: 16-bit control words, and 16-bit audio samples buffered in a small FIFO. It also flags malformed packets. The block sits between the link byte interface and the call-control and audio-playback logic.

## Interface
- PACKET_SIZE, 16: bytes per packet. Must be even and ≥4.
- FIFO_DEPTH, 16: audio sample FIFO entries. Must be a power of two.
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low (0 = reset).
- in_valid  in  1  in_data carries a packet byte this cycle. Gaps between bytes are allowed.
- in_data  in  8  packet byte.
- pkt_busy  out  1  high from header acceptance until the last byte of the packet.
- ctrl_valid  out  1  one-cycle pulse: ctrl_data is a new control word.
- ctrl_data  out  16  last received control word; held between pulses.
- audio_valid  out  1  sample FIFO not empty.
- audio_data  out  16  FIFO head, show-ahead.
- audio_rd  in  1  pop the FIFO head. Ignored when audio_valid=0.
- audio_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- err  out  1  one-cycle error pulse.
- err_code  out  2  01 bad header, 10 bad trailer, 11 sample overflow. Held until the next err.

## Operation
**Packet formats** (byte 0 first):
- Control: 8'h40, word[15:8], word[7:0], then PACKET_SIZE-3 padding bytes, which are ignored.
- Audio: 8'h80, then (PACKET_SIZE-2)/2 samples sent MSB first, then trailer 8'hFF. With PACKET_SIZE=16 this is 7 samples.

**Byte counter:** byte_cnt counts accepted bytes, 0..PACKET_SIZE-1. The last byte returns the FSM to IDLE and clears byte_cnt.

**FSM states:** IDLE, CTRL_HI, CTRL_LO, PAD, AUD_HI, AUD_LO, TRAILER, DISCARD. All transitions happen only on cycles with in_valid=1.
- IDLE:
  - 8'h40 → CTRL_HI.
  - 8'h80 → AUD_HI.
  - Any other value → DISCARD, with err/01.
- CTRL_HI → CTRL_LO. CTRL_LO → PAD, capturing the 16-bit word. PAD → IDLE on the last byte.
- AUD_HI → AUD_LO. AUD_LO writes {hi,lo} to the FIFO, then:
  - → TRAILER if byte_cnt = PACKET_SIZE-2;
  - otherwise → AUD_HI.
- TRAILER → IDLE. A byte ≠ 8'hFF raises err/10. Samples already written stay in the FIFO.
- DISCARD → IDLE on the last byte.

**Sample FIFO:**
- A write to a full FIFO with no simultaneous read drops the sample and raises err/11.
- A write and a read in the same cycle on a full FIFO are both accepted; count is unchanged.

**Error priority:** if overflow (11) and trailer (10) errors occur in the same cycle, overflow wins. This cannot happen with the formats above; the priority is listed for completeness.

**Arithmetic:** FIFO pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. audio_count is one bit wider, so it can represent FULL.

## Timing
- **Reset values:** pkt_busy=0, ctrl_valid=0, ctrl_data=0, audio_valid=0, audio_data=0, audio_count=0, err=0, err_code=0. FSM=IDLE, byte_cnt=0.
- **Reset mid-packet:** the partial packet is lost, the FIFO is flushed, and parsing restarts at a header.
- ctrl_valid pulses in the cycle after the CTRL_LO byte is accepted. ctrl_data updates in that same cycle.
- **Audio:** the FIFO write occurs on the clock edge that accepts the AUD_LO byte.
  - audio_valid and audio_count reflect the write in the next cycle.
  - audio_data is valid whenever audio_valid=1.
  - audio_rd takes effect on the same edge.
- err pulses in the cycle after the offending byte is accepted.
- pkt_busy rises in the cycle after the header is accepted and falls in the cycle after the last byte.
- **Throughput:** one byte per cycle sustained, with no back-pressure. Packets may be back-to-back.

## Structure
- Package transport_pkg:
  - HDR_CTRL=8'h40, HDR_AUDIO=8'h80, TRAILER=8'hFF;
  - err code localparams;
  - the FSM state enum.
- Sub-module sample_fifo: synchronous 16-bit show-ahead FIFO, FIFO_DEPTH deep, with wr_en/rd_en/full/empty/count and the same async active-low reset.
- Top level: FSM, byte counter, hi-byte holding register, control word register, error logic.

## Test plan
- **Control packet:** 40 12 34 followed by 13×00 → one ctrl_valid pulse with ctrl_data=16'h1234. No err. pkt_busy low after byte 16.
- **Audio packet:** 80, samples 0001..0007, FF → 7 FIFO entries. audio_count reaches 7. Popping yields 0001..0007 in order.
- **Bad inputs:**
  - Header 8'h55 → err/01. The next 15 bytes are ignored. A following control packet parses correctly.
  - Audio packet with trailer 8'hEE → 7 samples stored, err/10.
- **Overflow:** three audio packets with audio_rd=0 and FIFO_DEPTH=16 → 16 stored, 5 drops, err/11 on each drop. Repeat with audio_rd held high → no drops.
- **Gaps and reset:** random in_valid gaps inside packets give results identical to the gapless case. Asserting reset=0 mid-audio-packet clears the FIFO, all outputs return to reset values, and the next packet parses correctly.
